// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter sequencing FSM (BOOT -> FETCH <-> STALL).
// Picks the next PC from exception / jump / branch / pending redirect /
// sequential PC+4. It drives the PC register enable and data_in, issues
// instruction fetch requests, and counts completed PC updates.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_cur_i,
  input  logic        imem_ack_i,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        pc_ena_o,
  output logic [31:0] pc_next_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] fetch_cnt_o,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

  // Redirect priority levels; the numeric order is the arbitration order.
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_BR   = 2'd1,
    PRI_JMP  = 2'd2,
    PRI_EXC  = 2'd3
  } pri_e;

  state_e      state_q, state_d;
  pri_e        pend_pri_q, pend_pri_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  pri_e        redir_pri;
  logic [31:0] redir_tgt;
  logic [31:0] sel_pc;
  logic [31:0] cnt_q, cnt_d;
  logic        upd;

  // Highest-priority redirect pulse present this cycle, targets word aligned
  always_comb begin
    redir_pri = PRI_NONE;
    redir_tgt = '0;
    if (exc_i) begin
      redir_pri = PRI_EXC;
      redir_tgt = EXC_VECTOR;
    end else if (jump_i) begin
      redir_pri = PRI_JMP;
      redir_tgt = jump_target_i & ~32'd3;
    end else if (branch_taken_i) begin
      redir_pri = PRI_BR;
      redir_tgt = branch_target_i & ~32'd3;
    end
  end

  // Next-PC select: live redirect, else pending redirect, else PC+4 (wraps)
  always_comb begin
    sel_pc = pc_cur_i + 32'd4;
    if (redir_pri != PRI_NONE) begin
      sel_pc = redir_tgt;
    end else if (pend_pri_q != PRI_NONE) begin
      sel_pc = pend_tgt_q;
    end
  end

  // FSM next state and outputs; reset overrides outputs combinationally so
  // they fall to their reset values without waiting for a clock edge
  always_comb begin
    state_d    = state_q;
    upd        = 1'b0;
    pc_ena_o   = 1'b0;
    pc_next_o  = sel_pc;
    imem_req_o = 1'b0;
    case (state_q)
      BOOT: begin
        pc_ena_o  = 1'b1;
        pc_next_o = RESET_PC;
        state_d   = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (stall_i) state_d = STALL;
          else         upd     = 1'b1;
        end
      end
      STALL: begin
        if (!stall_i) begin
          upd     = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    if (upd) pc_ena_o = 1'b1;
    if (rst_i) begin
      state_d    = BOOT;
      upd        = 1'b0;
      pc_ena_o   = 1'b0;
      pc_next_o  = RESET_PC;
      imem_req_o = 1'b0;
    end
  end

  // Pending redirect: cleared by an update, otherwise captured when the new
  // pulse is at least as important as what is already held
  always_comb begin
    pend_pri_d = pend_pri_q;
    pend_tgt_d = pend_tgt_q;
    if (upd) begin
      pend_pri_d = PRI_NONE;
      pend_tgt_d = '0;
    end else if (redir_pri != PRI_NONE && redir_pri >= pend_pri_q) begin
      pend_pri_d = redir_pri;
      pend_tgt_d = redir_tgt;
    end
  end

  // Completed-update counter (BOOT load is not counted), wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (upd) cnt_d = cnt_q + 32'd1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pend_pri_q <= PRI_NONE;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_pri_q <= pend_pri_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr_o = pc_cur_i;
  assign fetch_cnt_o = cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h00400000, boot address loaded into the PC register after reset.
REQ-002 Parameter EXC_VECTOR, 32'h00400004, exception handler address.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc_cur  in  32  current PC (data_out of the PC register).
REQ-006 imem_ack  in  1  instruction memory has returned the word at imem_addr this cycle.
REQ-007 stall  in  1  pipeline hazard stall request; PC must not advance.
REQ-008 exc  in  1  exception pulse.
REQ-009 jump, jump_target  in  1, 32  unconditional redirect pulse and its target.
REQ-010 branch_taken, branch_target  in  1, 32  taken-branch pulse and its target.
REQ-011 pc_ena  out  1  write enable to the PC register (its ena).
REQ-012 pc_next  out  32  next PC value (PC register data_in).
REQ-013 imem_req, imem_addr  out  1, 32  fetch request and address; imem_addr = pc_cur combinationally.
REQ-014 fetch_cnt  out  32  count of completed PC updates since reset, excluding the BOOT load.
REQ-015 state_dbg  out  2  encoded FSM state: BOOT=0, FETCH=1, STALL=2.

Function
REQ-016 FSM states SHALL be BOOT, FETCH and STALL.
REQ-017 BOOT SHALL last exactly one cycle, drive pc_ena=1 and pc_next=RESET_PC, keep imem_req=0, then go to FETCH.
REQ-018 FETCH SHALL hold imem_req=1 until imem_ack=1; pc_ena=0 while waiting.
REQ-019 On an imem_ack cycle with stall=0: pc_ena=1 for that cycle, pc_next=selected next PC, fetch_cnt+1, remain in FETCH.
REQ-020 On an imem_ack cycle with stall=1: pc_ena=0, go to STALL.
REQ-021 STALL SHALL drive imem_req=0 and pc_ena=0 while stall=1; on the first cycle with stall=0: pc_ena=1, pc_next=selected, fetch_cnt+1, go to FETCH.
REQ-022 Next-PC selection priority: exc > jump > branch_taken > pending redirect > pc_cur+4.
REQ-023 Any redirect pulse in a cycle without a PC update SHALL be captured in a pending register (target and priority level).
REQ-024 A new redirect SHALL replace the pending one only if its priority is greater than or equal to the pending priority.
REQ-025 The pending register SHALL clear on the cycle the PC updates.
REQ-026 Redirects present on an update cycle SHALL be applied directly and SHALL not be stored.
REQ-027 Target bits [1:0] SHALL be forced to 0; EXC_VECTOR is used as is.
REQ-028 pc_cur+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
REQ-029 fetch_cnt SHALL wrap from 32'hFFFFFFFF to 0.
REQ-030 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-031 rst=1 SHALL immediately force state=BOOT, pc_ena=0, pc_next=RESET_PC, imem_req=0, fetch_cnt=0, and clear the pending redirect, regardless of clk.
REQ-032 Reset asserted mid-fetch or mid-stall SHALL abandon the fetch; after release, the first edge executes BOOT.

Verification
REQ-033 Release reset, imem_ack tied 1 -> BOOT loads 32'h00400000; pc_next then 32'h00400004, 32'h00400008; fetch_cnt=2 after the second update.
REQ-034 imem_ack delayed 3 cycles, jump=1 to 32'h00401002 in cycle 1 -> pending captured; on ack, pc_next=32'h00401000.
REQ-035 Pending branch, then exc while waiting -> on ack, pc_next=32'h00400004; pending cleared.
REQ-036 stall=1 on the ack cycle, held 4 cycles -> pc_ena=0 and imem_req=0 throughout; update to pc_cur+4 on the first cycle with stall=0.
REQ-037 pc_cur=32'hFFFFFFFC, ack, no redirect -> pc_next=32'h00000000.
REQ-038 rst pulse asynchronous to clk during STALL -> outputs reset immediately; BOOT follows release.
